cdc_fifo_unpacker: RTL and testbench



---
 rtl/cdc_fifo_pkg.sv | 14 +
 rtl/cdc_fifo_unpacker.sv | 116 +++++++++++
 tb/tb_cdc_fifo_unpacker.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_fifo_pkg.sv
// Shared types and helpers for the CDC FIFO receiver-side unpacker.
package cdc_fifo_pkg;

    // Counter width helper: at least one bit, even when only one beat exists.
    function automatic int safe_clog2(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        UNP_EMPTY,
        UNP_SHIFT
    } unp_state_t;

endpackage

// File: rtl/cdc_fifo_unpacker.sv
// Receiver-domain unpacker behind the CDC FIFO: dequeues DataWidth words and
// emits them as DataWidth/OutWidth beats, LSB beat first, one beat per clock.
// Optional macro CDC_UNPACK_WORDCNT_EN adds a 32-bit WordCount_DB output
// that counts dequeued words.
module cdc_fifo_unpacker
    import cdc_fifo_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int OutWidth  = 8
) (
    input  logic                 clk_DB,
    input  logic                 rst_n,
    input  logic                 DataValid_DB,
    input  logic [DataWidth-1:0] DataOut_DB,
    output logic                 Deq_DB,
`ifdef CDC_UNPACK_WORDCNT_EN
    output logic [31:0]          WordCount_DB,
`endif
    output logic                 BeatValid_DB,
    output logic [OutWidth-1:0]  BeatData_DB,
    output logic                 BeatLast_DB,
    input  logic                 BeatReady_DB
);

    localparam int Ratio        = DataWidth / OutWidth;
    localparam int BeatCntWidth = safe_clog2(Ratio);
    localparam logic [BeatCntWidth-1:0] LastCnt = BeatCntWidth'(Ratio - 1);

    if (DataWidth % OutWidth != 0) begin : g_bad_width
        $error("cdc_fifo_unpacker: DataWidth must be a multiple of OutWidth");
    end

    unp_state_t              state_q, state_d;
    logic [DataWidth-1:0]    shift_q, shift_d;
    logic [DataWidth-1:0]    shift_next;
    logic [BeatCntWidth-1:0] cnt_q, cnt_d;
    logic                    load;
    logic                    accept;
    logic                    last;

    // Next beat moves into the low slice; with a single beat per word there is nothing to shift.
    if (Ratio > 1) begin : g_shift
        assign shift_next = {{OutWidth{1'b0}}, shift_q[DataWidth-1:OutWidth]};
    end else begin : g_noshift
        assign shift_next = shift_q;
    end

    // Load/advance/drain decision; a word is loaded on the same edge the previous last beat leaves.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        cnt_d   = cnt_q;
        last    = (cnt_q == LastCnt);
        accept  = (state_q == UNP_SHIFT) && BeatReady_DB;
        load    = DataValid_DB && ((state_q == UNP_EMPTY) || (accept && last));
        if (load) begin
            shift_d = DataOut_DB;
            cnt_d   = '0;
            state_d = UNP_SHIFT;
        end else if (accept && !last) begin
            shift_d = shift_next;
            cnt_d   = cnt_q + 1'b1;
        end else if (accept) begin
            state_d = UNP_EMPTY;
        end
    end

    // Dequeue is the combinational load strobe, suppressed while reset is asserted.
    always_comb begin
        Deq_DB = load && rst_n;
    end

    // State, shift register and beat counter.
    always_ff @(posedge clk_DB or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UNP_EMPTY;
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs come straight from flops; last is qualified by valid so it reads 0 when idle.
    always_comb begin
        BeatValid_DB = (state_q == UNP_SHIFT);
        BeatData_DB  = shift_q[OutWidth-1:0];
        BeatLast_DB  = (state_q == UNP_SHIFT) && last;
    end

`ifdef CDC_UNPACK_WORDCNT_EN
    logic [31:0] wcnt_q, wcnt_d;

    // Word counter: +1 per dequeued word, wraps naturally.
    always_comb begin
        wcnt_d = wcnt_q;
        if (load) begin
            wcnt_d = wcnt_q + 32'd1;
        end
    end

    // Word counter register.
    always_ff @(posedge clk_DB or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q <= '0;
        end else begin
            wcnt_q <= wcnt_d;
        end
    end

    assign WordCount_DB = wcnt_q;
`endif

endmodule

// File: tb/tb_cdc_fifo_unpacker.sv
// Self-checking bench for cdc_fifo_unpacker: directed steps plus a random
// phase, checked against a queue-based model of words and expected beats.
module tb_cdc_fifo_unpacker;

    localparam int DW = 32;
    localparam int OW = 8;
    localparam int R  = DW / OW;

    typedef struct {
        logic [OW-1:0] d;
        logic          l;
    } beat_t;

    logic          clk;
    logic          rst_n;
    logic          dv;
    logic [DW-1:0] dout;
    logic          deq;
    logic          bv;
    logic [OW-1:0] bd;
    logic          bl;
    logic          br;

    logic          dv1;
    logic [DW-1:0] dout1;
    logic          deq1;
    logic          bv1;
    logic [DW-1:0] bd1;
    logic          bl1;
    logic          br1;

`ifdef CDC_UNPACK_WORDCNT_EN
    logic [31:0] wc;
    logic [31:0] wc1;
`endif

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] up_q[$];
    beat_t         exp_q[$];
    logic          offer;
    int            wc_exp;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    cdc_fifo_unpacker #(.DataWidth(DW), .OutWidth(OW)) dut (
        .clk_DB       (clk),
        .rst_n        (rst_n),
        .DataValid_DB (dv),
        .DataOut_DB   (dout),
        .Deq_DB       (deq),
`ifdef CDC_UNPACK_WORDCNT_EN
        .WordCount_DB (wc),
`endif
        .BeatValid_DB (bv),
        .BeatData_DB  (bd),
        .BeatLast_DB  (bl),
        .BeatReady_DB (br)
    );

    cdc_fifo_unpacker #(.DataWidth(DW), .OutWidth(DW)) dut_r1 (
        .clk_DB       (clk),
        .rst_n        (rst_n),
        .DataValid_DB (dv1),
        .DataOut_DB   (dout1),
        .Deq_DB       (deq1),
`ifdef CDC_UNPACK_WORDCNT_EN
        .WordCount_DB (wc1),
`endif
        .BeatValid_DB (bv1),
        .BeatData_DB  (bd1),
        .BeatLast_DB  (bl1),
        .BeatReady_DB (br1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of the main DUT, entered and left at a negedge.
    task automatic cycle();
        logic          acc;
        logic          dq;
        logic          exp_v;
        logic          exp_deq;
        logic [DW-1:0] w;
        dv   = offer && (up_q.size() != 0);
        dout = dv ? up_q[0] : DW'($urandom());
        #1;
        exp_v = (exp_q.size() != 0);
        chk("beat_valid", 32'(bv), 32'(exp_v));
        if (exp_v) begin
            chk("beat_data", 32'(bd), 32'(exp_q[0].d));
            chk("beat_last", 32'(bl), 32'(exp_q[0].l));
        end
        exp_deq = dv && (!exp_v || (br && exp_q.size() == 1));
        chk("deq", 32'(deq), 32'(exp_deq));
        acc = bv && br;
        dq  = deq;
        @(posedge clk);
        if (acc && exp_q.size() != 0) void'(exp_q.pop_front());
        if (dq && up_q.size() != 0) begin
            w = up_q.pop_front();
            for (int i = 0; i < R; i++) begin
                exp_q.push_back('{d: w[i*OW +: OW], l: (i == R - 1)});
            end
            wc_exp++;
        end
        @(negedge clk);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        offer = 1'b1;
        br    = 1'b1;
        while ((up_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_left", 32'(up_q.size() + exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n  = 1'b0;
        dv     = 1'b0;
        dout   = '0;
        br     = 1'b1;
        offer  = 1'b0;
        dv1    = 1'b0;
        dout1  = '0;
        br1    = 1'b1;
        wc_exp = 0;

        // Reset and idle
        #12;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("idle_data", 32'(bd), 32'd0);
            chk("idle_last", 32'(bl), 32'd0);
            chk("idle_r1_valid", 32'(bv1), 32'd0);
            cycle();
        end

        // Single word, ready held high
        up_q.push_back(32'hDDCCBBAA);
        offer = 1'b1;
        drain(12);

        // Two words back-to-back
        up_q.push_back(32'h03020100);
        up_q.push_back(32'h07060504);
        drain(16);

        // Stall at beat BB with the next word waiting upstream
        up_q.push_back(32'hDDCCBBAA);
        up_q.push_back(32'h0F0E0D0C);
        cycle();
        cycle();
        br = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("stall_data", 32'(bd), 32'h000000BB);
            chk("stall_last", 32'(bl), 32'd0);
            cycle();
        end
        chk("stall_data_end", 32'(bd), 32'h000000BB);
        drain(16);

        // Asynchronous reset after beat 22 has been accepted
        up_q.push_back(32'h44332211);
        up_q.push_back(32'h88776655);
        br = 1'b1;
        cycle();
        cycle();
        cycle();
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(bv), 32'd0);
        chk("rst_data", 32'(bd), 32'd0);
        chk("rst_last", 32'(bl), 32'd0);
        chk("rst_deq", 32'(deq), 32'd0);
        rst_n = 1'b1;
        exp_q.delete();
        wc_exp = 0;
        drain(16);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0 && up_q.size() < 4) up_q.push_back(DW'($urandom()));
            offer = ($urandom_range(0, 4) != 0);
            br    = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain(200);

`ifdef CDC_UNPACK_WORDCNT_EN
        chk("word_count", wc, 32'(wc_exp));
`endif

        // Ratio 1: five words at full rate, every beat last
        for (int c = 0; c <= 5; c++) begin
            dv1   = (c < 5);
            dout1 = 32'hA5A50000 + 32'(c);
            #1;
            chk("r1_deq", 32'(deq1), 32'(c < 5));
            if (c > 0) begin
                chk("r1_valid", 32'(bv1), 32'd1);
                chk("r1_data", bd1, 32'hA5A50000 + 32'(c - 1));
                chk("r1_last", 32'(bl1), 32'd1);
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("r1_idle", 32'(bv1), 32'd0);
`ifdef CDC_UNPACK_WORDCNT_EN
        chk("r1_word_count", wc1, 32'd5);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
